rf_wb_arbiter: RTL and testbench

//  Shares the register file's single write port (Awr/Din/WrEn) between two writeback

---
 rtl/rf_wb_arbiter_pkg.sv | 13 +
 rtl/rr_arb2.sv | 42 ++++
 rtl/rf_wb_arbiter.sv | 81 ++++++++
 tb/tb_rf_wb_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: default widths
// and the requester encoding used by the round-robin pointer.
package rf_wb_arbiter_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_M = 1'b1
  } reqId_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. The pointer records the last requester served,
// so on a tie the other side wins.
module rr_arb2
  import rf_wb_arbiter_pkg::*;
#(
  parameter bit PRIO_RST = 1'b0
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Hold,
  input  logic aReq,
  input  logic mReq,
  output logic aGnt,
  output logic mGnt
);

  reqId_t lastGnt;

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    aGnt = 1'b0;
    mGnt = 1'b0;
    if (!Hold) begin
      if (aReq && mReq) begin
        if (lastGnt == REQ_A) mGnt = 1'b1;
        else                  aGnt = 1'b1;
      end else begin
        aGnt = aReq;
        mGnt = mReq;
      end
    end
  end

  // Reset loads the opposite of the favoured side so the favoured side wins the first tie.
  // NOTE: state is updated with non-blocking assignments only.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)    lastGnt <= PRIO_RST ? REQ_A : REQ_M;
    else if (aGnt) lastGnt <= REQ_A;
    else if (mGnt) lastGnt <= REQ_M;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the regfile write port between ALU (A) and load (M) writeback,
// registers the write and forwards the in-flight value to both read ports.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_R0  = 1'b1,
  parameter bit PRIO_RST = 1'b0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              A_v,
  input  logic [ADDR_W-1:0] A_addr,
  input  logic [DATA_W-1:0] A_data,
  output logic              A_rdy,
  input  logic              M_v,
  input  logic [ADDR_W-1:0] M_addr,
  input  logic [DATA_W-1:0] M_data,
  output logic              M_rdy,
  input  logic              Hold,
  output logic [ADDR_W-1:0] Awr,
  output logic [DATA_W-1:0] Din,
  output logic              WrEn,
  input  logic [ADDR_W-1:0] Ard1,
  input  logic [ADDR_W-1:0] Ard2,
  output logic              Fwd1_v,
  output logic              Fwd2_v,
  output logic [DATA_W-1:0] Fwd_data,
  output logic              Busy1,
  output logic              Busy2
);

  logic              gntA;
  logic              gntM;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;
  logic              r0Rd1;
  logic              r0Rd2;

  rr_arb2 #(.PRIO_RST(PRIO_RST)) uArb (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .Hold (Hold),
    .aReq (A_v),
    .mReq (M_v),
    .aGnt (gntA),
    .mGnt (gntM)
  );

  assign A_rdy   = gntA;
  assign M_rdy   = gntM;
  assign selAddr = gntM ? M_addr : A_addr;
  assign selData = gntM ? M_data : A_data;

  // Writes to r0 are accepted but never issued when r0 is hard-wired.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      WrEn <= 1'b0;
      Awr  <= '0;
      Din  <= '0;
    end else begin
      WrEn <= (gntA || gntM) && !(ZERO_R0 && selAddr == '0);
      if (gntA || gntM) begin
        Awr <= selAddr;
        Din <= selData;
      end
    end
  end

  assign r0Rd1    = ZERO_R0 && Ard1 == '0;
  assign r0Rd2    = ZERO_R0 && Ard2 == '0;
  assign Fwd1_v   = WrEn && Ard1 == Awr && !r0Rd1;
  assign Fwd2_v   = WrEn && Ard2 == Awr && !r0Rd2;
  assign Fwd_data = Din;

  // A register is busy while a request targeting it waits in front of the arbiter.
  assign Busy1 = !r0Rd1 && ((A_v && !gntA && A_addr == Ard1) || (M_v && !gntM && M_addr == Ard1));
  assign Busy2 = !r0Rd2 && ((A_v && !gntA && A_addr == Ard2) || (M_v && !gntM && M_addr == Ard2));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level model with its own register file.
module tb_rf_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          A_v = 1'b0, M_v = 1'b0, Hold = 1'b0;
  logic [AW-1:0] A_addr = '0, M_addr = '0, Ard1 = '0, Ard2 = '0;
  logic [DW-1:0] A_data = '0, M_data = '0;
  logic          A_rdy, M_rdy, WrEn, Fwd1_v, Fwd2_v, Busy1, Busy2;
  logic [AW-1:0] Awr;
  logic [DW-1:0] Din, Fwd_data;

  rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1'b1), .PRIO_RST(1'b0)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .A_v(A_v), .A_addr(A_addr), .A_data(A_data), .A_rdy(A_rdy),
    .M_v(M_v), .M_addr(M_addr), .M_data(M_data), .M_rdy(M_rdy),
    .Hold(Hold), .Awr(Awr), .Din(Din), .WrEn(WrEn),
    .Ard1(Ard1), .Ard2(Ard2), .Fwd1_v(Fwd1_v), .Fwd2_v(Fwd2_v),
    .Fwd_data(Fwd_data), .Busy1(Busy1), .Busy2(Busy2)
  );

  always #5 Clk = ~Clk;

  // Register file driven by the DUT's write port; its read is the decode Dout.
  logic [DW-1:0] rf [32] = '{default: '0};
  always @(posedge Clk) if (WrEn) rf[Awr] <= Din;

  // Transaction-level model: who was served last, the issued write, and the register contents.
  int            nVec = 0;
  int            nFail = 0;
  bit            lastWasM;
  bit            expWrEn;
  logic [AW-1:0] expAwr;
  logic [DW-1:0] expDin;
  logic [DW-1:0] modelRf [32] = '{default: '0};
  bit            accA, accM, obsA, obsM, obsBusy1;

  function automatic bit waiting(bit v, bit g, logic [AW-1:0] a, logic [AW-1:0] r);
    return v && !g && a == r && r != '0;
  endfunction

  function automatic bit fwdHit(logic [AW-1:0] r);
    return expWrEn && r == expAwr && r != '0;
  endfunction

  task automatic resetModel();
    expWrEn  = 1'b0;
    expAwr   = '0;
    expDin   = '0;
    lastWasM = 1'b1;
  endtask

  task automatic doReset();
    Rst_n = 1'b0;
    #2;
    Rst_n = 1'b1;
    resetModel();
  endtask

  // One clock cycle: inputs are already applied by the caller.
  task automatic step();
    bit gA, gM;
    logic [AW-1:0] wa;
    #1;
    gA = 1'b0;
    gM = 1'b0;
    if (!Hold) begin
      if (A_v && M_v) begin
        gA = lastWasM;
        gM = !lastWasM;
      end else begin
        gA = A_v;
        gM = M_v;
      end
    end
    nVec++; if (A_rdy !== gA) begin nFail++; $display("FAIL A_rdy got %0b want %0b t=%0t", A_rdy, gA, $time); end
    nVec++; if (M_rdy !== gM) begin nFail++; $display("FAIL M_rdy got %0b want %0b t=%0t", M_rdy, gM, $time); end
    nVec++; if (Busy1 !== (waiting(A_v, gA, A_addr, Ard1) || waiting(M_v, gM, M_addr, Ard1))) begin
      nFail++; $display("FAIL Busy1 got %0b t=%0t", Busy1, $time); end
    nVec++; if (Busy2 !== (waiting(A_v, gA, A_addr, Ard2) || waiting(M_v, gM, M_addr, Ard2))) begin
      nFail++; $display("FAIL Busy2 got %0b t=%0t", Busy2, $time); end
    nVec++; if (Fwd1_v !== fwdHit(Ard1)) begin nFail++; $display("FAIL Fwd1_v got %0b want %0b t=%0t", Fwd1_v, fwdHit(Ard1), $time); end
    nVec++; if (Fwd2_v !== fwdHit(Ard2)) begin nFail++; $display("FAIL Fwd2_v got %0b want %0b t=%0t", Fwd2_v, fwdHit(Ard2), $time); end
    if (expWrEn) begin
      nVec++; if (Fwd_data !== expDin) begin nFail++; $display("FAIL Fwd_data got %h want %h", Fwd_data, expDin); end
    end
    nVec++; if (rf[Ard1] !== modelRf[Ard1]) begin
      nFail++; $display("FAIL Dout1 r%0d got %h want %h t=%0t", Ard1, rf[Ard1], modelRf[Ard1], $time); end
    obsA = A_rdy;
    obsM = M_rdy;
    obsBusy1 = Busy1;
    @(posedge Clk);
    if (expWrEn) modelRf[expAwr] = expDin;
    if (gA || gM) begin
      wa       = gA ? A_addr : M_addr;
      expWrEn  = wa != '0;
      expAwr   = wa;
      expDin   = gA ? A_data : M_data;
      lastWasM = gM;
    end else begin
      expWrEn = 1'b0;
    end
    accA = gA;
    accM = gM;
    #1;
    nVec++; if (WrEn !== expWrEn) begin nFail++; $display("FAIL WrEn got %0b want %0b t=%0t", WrEn, expWrEn, $time); end
    nVec++; if (Awr !== expAwr) begin nFail++; $display("FAIL Awr got %0d want %0d t=%0t", Awr, expAwr, $time); end
    nVec++; if (Din !== expDin) begin nFail++; $display("FAIL Din got %h want %h t=%0t", Din, expDin, $time); end
  endtask

  task automatic idle(int n);
    A_v = 1'b0;
    M_v = 1'b0;
    Hold = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    resetModel();
    #3;
    nVec++; if (WrEn !== 1'b0) begin nFail++; $display("FAIL reset_WrEn got %0b want 0", WrEn); end
    nVec++; if (Awr !== '0) begin nFail++; $display("FAIL reset_Awr got %0d want 0", Awr); end
    nVec++; if (Din !== '0) begin nFail++; $display("FAIL reset_Din got %h want 0", Din); end
    #4;
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_a_only();
    A_v = 1'b1; A_addr = 5'd5; A_data = 32'hDEADBEEF; Ard1 = 5'd5; Ard2 = 5'd0;
    step();
    A_v = 1'b0;
    nVec++; if (obsA !== 1'b1) begin nFail++; $display("FAIL a_only_rdy got %0b want 1", obsA); end
    nVec++; if ({WrEn, Awr, Din} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      nFail++; $display("FAIL a_only_write got %0b/%0d/%h want 1/5/deadbeef", WrEn, Awr, Din); end
    nVec++; if (Fwd1_v !== 1'b1) begin nFail++; $display("FAIL a_only_fwd got %0b want 1", Fwd1_v); end
    step();
    #1;
    nVec++; if (rf[5'd5] !== 32'hDEADBEEF) begin nFail++; $display("FAIL a_only_dout got %h want deadbeef", rf[5'd5]); end
    idle(1);
  endtask

  task automatic test_reset_mid();
    A_v = 1'b1; A_addr = 5'd12; A_data = 32'hA5A5_0001;
    step();
    A_v = 1'b0;
    #1;
    Rst_n = 1'b0;
    #1;
    nVec++; if ({WrEn, Awr, Din} !== '0) begin
      nFail++; $display("FAIL reset_mid got %0b/%0d/%h want 0/0/0", WrEn, Awr, Din); end
    Rst_n = 1'b1;
    resetModel();
    idle(2);
    nVec++; if (rf[5'd12] !== 32'h0) begin nFail++; $display("FAIL reset_mid_dropped got %h want 0", rf[5'd12]); end
  endtask

  task automatic test_contention();
    logic [31:0] seq;
    int busyCnt;
    seq = "";
    busyCnt = 0;
    doReset();
    A_v = 1'b1; A_addr = 5'd3; A_data = 32'h100;
    M_v = 1'b1; M_addr = 5'd4; M_data = 32'h200;
    Ard1 = 5'd4; Ard2 = 5'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      seq = {seq[23:0], (obsA ? "A" : (obsM ? "M" : "-"))};
      if (obsBusy1) busyCnt++;
      if (accA) A_data = A_data + 1;
      if (accM) M_data = M_data + 1;
    end
    nVec++; if (seq !== "AMAM") begin nFail++; $display("FAIL contention_order got %s want AMAM", seq); end
    nVec++; if (busyCnt != 2) begin nFail++; $display("FAIL contention_busy got %0d want 2", busyCnt); end
    idle(2);
  endtask

  task automatic test_r0();
    M_v = 1'b1; M_addr = 5'd0; M_data = 32'h1234; Ard2 = 5'd0;
    step();
    M_v = 1'b0;
    nVec++; if (obsM !== 1'b1) begin nFail++; $display("FAIL r0_rdy got %0b want 1", obsM); end
    nVec++; if (WrEn !== 1'b0) begin nFail++; $display("FAIL r0_wren got %0b want 0", WrEn); end
    nVec++; if (Fwd2_v !== 1'b0) begin nFail++; $display("FAIL r0_fwd got %0b want 0", Fwd2_v); end
    idle(1);
  endtask

  task automatic test_hold();
    doReset();
    A_v = 1'b1; A_addr = 5'd9; A_data = 32'h99;
    step();
    A_addr = 5'd10; A_data = 32'hAA;
    M_v = 1'b1; M_addr = 5'd11; M_data = 32'hBB;
    Hold = 1'b1;
    for (int i = 0; i < 3; i++) step();
    nVec++; if (WrEn !== 1'b0) begin nFail++; $display("FAIL hold_wren got %0b want 0", WrEn); end
    Hold = 1'b0;
    step();
    nVec++; if (obsM !== 1'b1) begin nFail++; $display("FAIL hold_resume got M_rdy=%0b want 1", obsM); end
    M_v = 1'b0;
    step();
    idle(2);
    nVec++; if (rf[5'd10] !== 32'hAA || rf[5'd11] !== 32'hBB) begin
      nFail++; $display("FAIL hold_writes got %h/%h want aa/bb", rf[5'd10], rf[5'd11]); end
  endtask

  task automatic test_same_addr();
    doReset();
    A_v = 1'b1; A_addr = 5'd7; A_data = 32'h1;
    M_v = 1'b1; M_addr = 5'd7; M_data = 32'h2;
    Ard1 = 5'd7;
    step();
    A_v = 1'b0;
    step();
    M_v = 1'b0;
    idle(2);
    nVec++; if (rf[5'd7] !== 32'h2) begin nFail++; $display("FAIL same_addr r7 got %h want 2", rf[5'd7]); end
  endtask

  task automatic test_random(int n);
    accA = 1'b0;
    accM = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!A_v || accA) begin
        A_v = $urandom_range(0, 9) < 6;
        A_addr = AW'($urandom_range(0, 7));
        A_data = $urandom;
      end else if ($urandom_range(0, 9) == 0) A_v = 1'b0;
      if (!M_v || accM) begin
        M_v = $urandom_range(0, 9) < 6;
        M_addr = AW'($urandom_range(0, 7));
        M_data = $urandom;
      end else if ($urandom_range(0, 9) == 0) M_v = 1'b0;
      Hold = $urandom_range(0, 9) == 0;
      Ard1 = $urandom_range(0, 1) ? expAwr : AW'($urandom_range(0, 7));
      Ard2 = AW'($urandom_range(0, 7));
      step();
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_reset_mid();
    test_contention();
    test_r0();
    test_hold();
    test_same_addr();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
